// File: rtl/mem_access_unit.sv
// Load/store access unit: maps datapath byte/half/word requests onto a
// word-wide memory port with lane enables, a wait-state timeout and load extension.
module mem_access_unit #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        is_store,
   input  logic [2:0]  mem_select,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] rdata,
   output logic        err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_t;

   state_t           state, state_nxt;
   logic             store_q, signed_q;
   logic [1:0]       size_q, lane_q;
   logic [3:0]       be_q;
   logic [CNT_W-1:0] wait_cnt;
   logic             accept, illegal, timeout;
   logic [3:0]       be_calc;
   logic [31:0]      wdata_calc, load_ext;
   logic [7:0]       byte_lane;
   logic [15:0]      half_lane;

   assign accept  = (state == S_IDLE) && start;
   assign timeout = (wait_cnt == CNT_W'(TIMEOUT - 1));

   // Legality, lane enables and replicated store data from the raw request.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      illegal    = 1'b0;
      be_calc    = 4'b1111;
      wdata_calc = wdata;
      case (mem_select[1:0])
         SZ_BYTE: begin
            be_calc    = 4'b0001 << addr[1:0];
            wdata_calc = {4{wdata[7:0]}};
         end
         SZ_HALF: begin
            illegal    = addr[0];
            be_calc    = addr[1] ? 4'b1100 : 4'b0011;
            wdata_calc = {2{wdata[15:0]}};
         end
         SZ_WORD: illegal = |addr[1:0];
         default: illegal = 1'b1;
      endcase
   end

   always_comb begin
      byte_lane = mem_rdata[{lane_q, 3'b000} +: 8];
      half_lane = mem_rdata[{lane_q[1], 4'b0000} +: 16];
      case (size_q)
         SZ_BYTE: load_ext = {{24{signed_q & byte_lane[7]}}, byte_lane};
         SZ_HALF: load_ext = {{16{signed_q & half_lane[15]}}, half_lane};
         default: load_ext = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = (state != S_IDLE);
      done      = 1'b0;
      err       = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_be    = 4'b0000;
      case (state)
         S_IDLE: if (start) state_nxt = illegal ? S_ERR : S_REQ;
         S_REQ: begin
            mem_req = 1'b1;
            mem_we  = store_q;
            mem_be  = be_q;
            // An ack on the last allowed cycle still wins over the timeout.
            if (mem_ack)      state_nxt = S_DONE;
            else if (timeout) state_nxt = S_ERR;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: begin
            done      = 1'b1;
            err       = 1'b1;
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         store_q   <= 1'b0;
         signed_q  <= 1'b0;
         size_q    <= 2'd0;
         lane_q    <= 2'd0;
         be_q      <= 4'b0000;
         mem_addr  <= 32'h0;
         mem_wdata <= 32'h0;
         rdata     <= 32'h0;
         wait_cnt  <= '0;
      end else begin
         if (accept) begin
            store_q   <= is_store;
            signed_q  <= mem_select[2];
            size_q    <= mem_select[1:0];
            lane_q    <= addr[1:0];
            be_q      <= be_calc;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_wdata <= wdata_calc;
         end
         if (state == S_REQ && mem_ack && !store_q) rdata <= load_ext;
         // Held at zero outside REQ, so it is clear on every entry.
         if (state != S_REQ) wait_cnt <= '0;
         else if (!mem_ack)  wait_cnt <= wait_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed accesses push expected
// completions; a monitor checks each done pulse against the queue head.
module tb_mem_access_unit;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          lat;
      int          start_cyc;
   } exp_t;

   logic        clk, reset, start, is_store;
   logic [2:0]  mem_select;
   logic [31:0] addr, wdata, rdata, mem_addr, mem_wdata, mem_rdata;
   logic        busy, done, err, mem_req, mem_we, mem_ack;
   logic [3:0]  mem_be;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          ack_wait = -1;
   int          req_cnt = 0;
   logic [31:0] rd_word = 32'h0;

   mem_access_unit #(.TIMEOUT(16)) dut (
      .clk(clk), .reset(reset), .start(start), .is_store(is_store),
      .mem_select(mem_select), .addr(addr), .wdata(wdata), .busy(busy),
      .done(done), .rdata(rdata), .err(err), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory model: acks after ack_wait stalled REQ cycles (never when negative).
   always @(negedge clk) begin
      if (mem_req) begin
         mem_ack   = (req_cnt == ack_wait);
         mem_rdata = rd_word;
         req_cnt++;
      end else begin
         mem_ack   = 1'b0;
         mem_rdata = 32'h0;
         req_cnt   = 0;
      end
   end

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (reset && done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("err", err, e.err);
            check("rdata", rdata, e.rdata);
            check("latency", cyc - e.start_cyc, e.lat);
         end
      end
   end

   task automatic do_access(input logic st, input logic [2:0] sel, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rword, input int aw,
                            input logic exp_err, input logic [31:0] exp_rdata, input int exp_lat,
                            input int exp_req, input logic [31:0] exp_addr,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata);
      int          req_n, waited;
      logic        stable;
      logic [68:0] snap;
      @(negedge clk);
      is_store = st; mem_select = sel; addr = a; wdata = wd;
      rd_word = rword; ack_wait = aw; start = 1'b1;
      sb.push_back('{exp_err, exp_rdata, exp_lat, cyc});
      @(negedge clk);
      // Scramble inputs and re-pulse start: the unit must use its captured copy and ignore start.
      is_store = ~st; mem_select = ~sel; addr = 32'hDEAD_BEEF; wdata = 32'h5555_1234;
      req_n = 0; waited = 0; stable = 1'b1; snap = '0;
      while (!done && waited < 40) begin
         if (mem_req) begin
            if (req_n == 0) begin
               check("mem_addr", mem_addr, exp_addr);
               check("mem_be", {28'h0, mem_be}, {28'h0, exp_be});
               check("mem_we", mem_we, st);
               check("mem_wdata", mem_wdata, exp_wdata);
               check("busy", busy, 1'b1);
               snap = {mem_we, mem_be, mem_addr, mem_wdata};
            end else if (snap !== {mem_we, mem_be, mem_addr, mem_wdata}) begin
               stable = 1'b0;
            end
            req_n++;
         end else begin
            check("idle_strobes", {27'h0, mem_we, mem_be}, 32'h0);
         end
         @(negedge clk);
         start = 1'b0;
         waited++;
      end
      start = 1'b0;
      check("done_seen", done, 1'b1);
      check("req_cycles", req_n, exp_req);
      check("req_stable", stable, 1'b1);
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; is_store = 1'b0; mem_select = 3'b000;
      addr = 32'h0; wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
      #3;
      check("rst_busy", busy, 1'b0);
      check("rst_done_err", {done, err}, 2'b00);
      check("rst_req_we", {mem_req, mem_we}, 2'b00);
      check("rst_be", {28'h0, mem_be}, 32'h0);
      check("rst_rdata", rdata, 32'h0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // st sel    addr        wdata         rword         aw  err rdata         lat req  mem_addr      be       mem_wdata
      do_access(0, 3'b100, 32'h103, 32'h1122_3344, 32'h8011_2233, 0, 0, 32'hFFFF_FF80, 2, 1, 32'h100, 4'b1000, 32'h4444_4444);
      do_access(0, 3'b001, 32'h022, 32'h0000_BEEF, 32'h9ABC_1234, 0, 0, 32'h0000_9ABC, 2, 1, 32'h020, 4'b1100, 32'hBEEF_BEEF);
      do_access(0, 3'b101, 32'h022, 32'h0000_BEEF, 32'h9ABC_1234, 0, 0, 32'hFFFF_9ABC, 2, 1, 32'h020, 4'b1100, 32'hBEEF_BEEF);
      do_access(1, 3'b000, 32'h041, 32'h0000_00A5, 32'h1234_5678, 3, 0, 32'hFFFF_9ABC, 5, 4, 32'h040, 4'b0010, 32'hA5A5_A5A5);
      do_access(0, 3'b010, 32'h006, 32'h0,         32'h0,        0, 1, 32'hFFFF_9ABC, 1, 0, 32'h0,   4'b0000, 32'h0);
      do_access(0, 3'b010, 32'h200, 32'h0,         32'h1111_1111, -1, 1, 32'hFFFF_9ABC, 17, 16, 32'h200, 4'b1111, 32'h0);
      do_access(0, 3'b010, 32'h300, 32'h0,         32'hCAFE_F00D, 15, 0, 32'hCAFE_F00D, 17, 16, 32'h300, 4'b1111, 32'h0);
      do_access(0, 3'b011, 32'h000, 32'h0,         32'h0,        0, 1, 32'hCAFE_F00D, 1, 0, 32'h0,   4'b0000, 32'h0);
      do_access(0, 3'b101, 32'h010, 32'h0,         32'h1234_8001, 0, 0, 32'hFFFF_8001, 2, 1, 32'h010, 4'b0011, 32'h0);
      do_access(0, 3'b110, 32'h008, 32'h0,         32'h8000_0001, 1, 0, 32'h8000_0001, 3, 2, 32'h008, 4'b1111, 32'h0);
      do_access(0, 3'b001, 32'h003, 32'h0,         32'h0,        0, 1, 32'h8000_0001, 1, 0, 32'h0,   4'b0000, 32'h0);

      // Reset in the middle of a stalled access: abandoned without a done pulse.
      @(negedge clk);
      is_store = 1'b0; mem_select = 3'b010; addr = 32'h400; ack_wait = -1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("abort_req_before", mem_req, 1'b1);
      #2 reset = 1'b0;
      #1;
      check("abort_req_async", mem_req, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_rdata", rdata, 32'h0);
      check("abort_mem_addr", mem_addr, 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      do_access(0, 3'b000, 32'h002, 32'h0, 32'h00AB_0000, 0, 0, 32'h0000_00AB, 2, 1, 32'h000, 4'b0100, 32'h0);

      repeat (3) @(negedge clk);
      check("sb_empty", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: TIMEOUT, 16, number of cycles mem_req may wait for mem_ack before the access is aborted with an error.
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  request pulse from the datapath; sampled only in IDLE.
REQ-005 is_store  in  1  1 = store (decoder MemW), 0 = load.
REQ-006 mem_select  in  3  {loadSigned, size[1:0]}; size 0 = BYTE, 1 = HALF, 2 = WORD, 3 = reserved.
REQ-007 addr  in  32  byte address from the ALU result.
REQ-008 wdata  in  32  store data (register Rd value).
REQ-009 busy  out  1  high from the cycle after start is accepted until the cycle after done.
REQ-010 done  out  1  one-cycle pulse marking access completion.
REQ-011 rdata  out  32  extended load result; valid while done=1, held until the next done.
REQ-012 err  out  1  valid with done; 1 = misaligned, reserved size, or timeout.
REQ-013 mem_req  out  1  memory request.
REQ-014 mem_we  out  1  memory write enable.
REQ-015 mem_addr  out  32  word-aligned address, {addr[31:2], 2'b00}.
REQ-016 mem_be  out  4  byte-lane enables.
REQ-017 mem_wdata  out  32  lane-replicated store data.
REQ-018 mem_ack  in  1  memory completion; for loads, mem_rdata is valid in the same cycle.
REQ-019 mem_rdata  in  32  memory read word.

Function
REQ-020 The FSM SHALL use four states: IDLE, REQ, DONE, ERR.
REQ-021 IDLE with start=1: the unit SHALL register is_store, mem_select, addr and wdata.
  - Legal request: next state REQ.
  - Illegal request: next state ERR.
REQ-022 IDLE with start=0: the unit SHALL remain in IDLE.
REQ-023 While busy=1, start SHALL be ignored; requests are never queued.
REQ-024 An access SHALL be illegal for any of these conditions:
  - size = 3;
  - HALF with addr[0] = 1;
  - WORD with addr[1:0] != 0.
REQ-025 In REQ, the following outputs SHALL be driven from registers and held stable until the cycle mem_ack=1:
  - mem_req = 1;
  - mem_we = is_store;
  - mem_addr, mem_be, mem_wdata.
REQ-026 Byte enables SHALL be:
  - BYTE: 4'b0001 << addr[1:0];
  - HALF: addr[1] ? 4'b1100 : 4'b0011;
  - WORD: 4'b1111.
  - Loads drive the same enables as stores.
REQ-027 Store data SHALL be lane-replicated:
  - BYTE: {4{wdata[7:0]}};
  - HALF: {2{wdata[15:0]}};
  - WORD: wdata.
REQ-028 In REQ with mem_ack=1, the unit SHALL go to DONE.
  - Loads capture the extracted lane: BYTE mem_rdata[8*addr[1:0] +: 8], HALF mem_rdata[16*addr[1] +: 16], WORD all 32 bits.
  - The lane is zero-extended, or sign-extended when loadSigned = 1.
  - loadSigned is ignored for WORD.
REQ-029 Stores SHALL leave rdata unchanged.
REQ-030 A wait counter SHALL clear on entry to REQ and increment on each REQ cycle with mem_ack=0.
  - When the counter reaches TIMEOUT-1 with mem_ack=0, the next state is ERR and mem_req drops.
  - mem_ack arriving on that same cycle takes priority: the next state is DONE.
REQ-031 DONE SHALL assert done=1 and err=0 for one cycle, then return to IDLE.
REQ-032 ERR SHALL assert done=1 and err=1 for one cycle, then return to IDLE.
  - Illegal accesses never assert mem_req.
REQ-033 Completion latency, from the start cycle to the done cycle, SHALL be exactly 2 + (number of REQ cycles without ack).
  - Zero-wait access: done 2 cycles after start.
  - Illegal access: done 1 cycle after start.
REQ-034 mem_req, mem_we and mem_be SHALL be 0 in every state except REQ.

Reset
REQ-035 reset=0 SHALL immediately, without waiting for a clock edge, force:
  - state IDLE;
  - busy, done, err, mem_req, mem_we = 0;
  - mem_be = 4'b0000;
  - rdata, mem_addr, mem_wdata = 0;
  - wait counter = 0.
REQ-036 Reset during REQ SHALL abandon the access with no done pulse.
  - The first start after reset is released is accepted normally.

Verification
REQ-037 Signed byte load: addr=0x103, mem_select=3'b100, ack on first REQ cycle, mem_rdata=0x80112233 -> mem_addr=0x100, mem_be=4'b1000, done 2 cycles after start, rdata=0xFFFFFF80, err=0.
REQ-038 Unsigned half load: addr=0x22, mem_select=3'b001, mem_rdata=0x9ABC1234 -> mem_be=4'b1100, rdata=0x00009ABC.
  - Repeat with mem_select=3'b101 -> rdata=0xFFFF9ABC.
REQ-039 Byte store: is_store=1, addr=0x41, mem_select=3'b000, wdata=0x000000A5, ack after 3 wait cycles -> mem_we=1, mem_be=4'b0010, mem_wdata=0xA5A5A5A5, all memory outputs stable for 4 cycles, done 5 cycles after start, rdata unchanged.
REQ-040 Misaligned word: addr=0x6, mem_select=3'b010 -> mem_req never asserts, done=1 and err=1 one cycle after start.
REQ-041 Timeout: mem_ack held 0 -> mem_req high for exactly 16 cycles, then done=1 and err=1.
  - Separate run: ack on the 16th REQ cycle -> done=1, err=0.
REQ-042 Reset mid-access: assert reset during REQ -> mem_req=0 with no clock edge, no done pulse; a new start after release completes normally.
